// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage pipeline: data-memory access with configurable wait states, and the MEM/WB register.
// Optional macro MEM_FWD_EN adds forwarding and hazard outputs for the instruction that currently occupies MEM.
module mem_wb_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [4:0]  mdestReg,
    input  logic [31:0] mr,
    input  logic [31:0] mqb,
    output logic        mstall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wdestReg,
    output logic [31:0] wr,
    output logic [31:0] wdo
`ifdef MEM_FWD_EN
    ,
    output logic        fwd_mvalid,
    output logic [4:0]  fwd_mdest,
    output logic [31:0] fwd_mdata,
    output logic        fwd_mbusy
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit        SINGLE_CYCLE = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD    = SINGLE_CYCLE ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                access, final_cyc, stall;
    logic [ADDR_W-1:0]   idx;
    logic                unused_addr_bits;

    assign access = mm2reg | mwmem;
    assign idx    = mr[ADDR_W+1:2];
    // Byte offset and high address bits are deliberately ignored so addresses wrap.
    assign unused_addr_bits = ^{mr[31:ADDR_W+2], mr[1:0]};

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        final_cyc = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (SINGLE_CYCLE) begin
                        final_cyc = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    final_cyc = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mstall = resetn & stall;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wwreg    <= 1'b0;
            wm2reg   <= 1'b0;
            wdestReg <= 5'd0;
            wr       <= 32'd0;
            wdo      <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall) begin
                // Bubble: controls cleared, data fields keep their last value.
                wwreg  <= 1'b0;
                wm2reg <= 1'b0;
            end else begin
                wwreg    <= mwreg;
                wm2reg   <= mm2reg;
                wdestReg <= mdestReg;
                wr       <= mr;
                wdo      <= mm2reg ? mem[idx] : 32'd0;
            end
        end
    end

    // NOTE: the memory array is intentionally not reset; only the write is gated by reset.
    always_ff @(posedge clk) begin
        if (resetn && final_cyc && mwmem) begin
            mem[idx] <= mqb;
        end
    end

`ifdef MEM_FWD_EN
    assign fwd_mvalid = resetn & mwreg & ~mm2reg;
    assign fwd_mdest  = resetn ? mdestReg : 5'd0;
    assign fwd_mdata  = resetn ? mr : 32'd0;
    assign fwd_mbusy  = resetn & mm2reg & mwreg;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: two instances (WAIT_STATES=0 and 2) against a transaction-level memory model.
module tb_mem_wb_stage;

    localparam int WS [2] = '{0, 2};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        mwreg_v [2];
    logic        mm2reg_v [2];
    logic        mwmem_v [2];
    logic [4:0]  mdest_v [2];
    logic [31:0] mr_v [2];
    logic [31:0] mqb_v [2];
    logic        mstall_v [2];
    logic        wwreg_v [2];
    logic        wm2reg_v [2];
    logic [4:0]  wdest_v [2];
    logic [31:0] wr_v [2];
    logic [31:0] wdo_v [2];

`ifdef MEM_FWD_EN
    logic        fv [2];
    logic [4:0]  fd [2];
    logic [31:0] fdat [2];
    logic        fb [2];
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl   [2][256];
    bit          known [2][256];

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_W(8), .WAIT_STATES(0)) dut_w0 (
        .clk(clk), .resetn(resetn),
        .mwreg(mwreg_v[0]), .mm2reg(mm2reg_v[0]), .mwmem(mwmem_v[0]),
        .mdestReg(mdest_v[0]), .mr(mr_v[0]), .mqb(mqb_v[0]),
        .mstall(mstall_v[0]), .wwreg(wwreg_v[0]), .wm2reg(wm2reg_v[0]),
        .wdestReg(wdest_v[0]), .wr(wr_v[0]), .wdo(wdo_v[0])
`ifdef MEM_FWD_EN
        , .fwd_mvalid(fv[0]), .fwd_mdest(fd[0]), .fwd_mdata(fdat[0]), .fwd_mbusy(fb[0])
`endif
    );

    mem_wb_stage #(.ADDR_W(8), .WAIT_STATES(2)) dut_w2 (
        .clk(clk), .resetn(resetn),
        .mwreg(mwreg_v[1]), .mm2reg(mm2reg_v[1]), .mwmem(mwmem_v[1]),
        .mdestReg(mdest_v[1]), .mr(mr_v[1]), .mqb(mqb_v[1]),
        .mstall(mstall_v[1]), .wwreg(wwreg_v[1]), .wm2reg(wm2reg_v[1]),
        .wdestReg(wdest_v[1]), .wr(wr_v[1]), .wdo(wdo_v[1])
`ifdef MEM_FWD_EN
        , .fwd_mvalid(fv[1]), .fwd_mdest(fd[1]), .fwd_mdata(fdat[1]), .fwd_mbusy(fb[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic wreg, input logic m2reg, input logic wmem,
                         input logic [4:0] dest, input logic [31:0] r, input logic [31:0] qb);
        mwreg_v[s]  = wreg;
        mm2reg_v[s] = m2reg;
        mwmem_v[s]  = wmem;
        mdest_v[s]  = dest;
        mr_v[s]     = r;
        mqb_v[s]    = qb;
    endtask

    task automatic nop(input int s);
        drive(s, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // One instruction through MEM: expected stall length and MEM/WB contents come from the model.
    task automatic issue(input int s, input logic wreg, input logic m2reg, input logic wmem,
                         input logic [4:0] dest, input logic [31:0] r, input logic [31:0] qb);
        int n;
        int idx;
        logic [31:0] exp_wdo;
        drive(s, wreg, m2reg, wmem, dest, r, qb);
        n = (m2reg || wmem) ? WS[s] : 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("stall_high", 32'(mstall_v[s]), 32'd1);
            if (k > 0) begin
                check("bubble_wwreg", 32'(wwreg_v[s]), 32'd0);
                check("bubble_wm2reg", 32'(wm2reg_v[s]), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("final_stall_low", 32'(mstall_v[s]), 32'd0);
        idx = int'((r >> 2) % 256);
        exp_wdo = m2reg ? mdl[s][idx] : 32'd0;
        if (wmem) begin
            mdl[s][idx]   = qb;
            known[s][idx] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("wwreg", 32'(wwreg_v[s]), 32'(wreg));
        check("wm2reg", 32'(wm2reg_v[s]), 32'(m2reg));
        check("wdestReg", 32'(wdest_v[s]), 32'(dest));
        check("wr", wr_v[s], r);
        check("wdo", wdo_v[s], exp_wdo);
    endtask

    initial begin
        int s;
        int kind;
        int idx;
        logic [31:0] r;

        for (int i = 0; i < 2; i++) drive(i, 1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 32'd0);

        // Reset held for three edges with a register-writing instruction driven.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            check("rst_wwreg", 32'(wwreg_v[i]), 32'd0);
            check("rst_wm2reg", 32'(wm2reg_v[i]), 32'd0);
            check("rst_wdest", 32'(wdest_v[i]), 32'd0);
            check("rst_wr", wr_v[i], 32'd0);
            check("rst_wdo", wdo_v[i], 32'd0);
            check("rst_mstall", 32'(mstall_v[i]), 32'd0);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("post_rst_wwreg", 32'(wwreg_v[i]), 32'd1);
            check("post_rst_wr", wr_v[i], 32'h1234);
            nop(i);
        end

        // ALU pass-through on the wait-state instance.
        issue(1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'd0);

        // Store then load to the same word through a misaligned address.
        issue(1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'hCAFEF00D);
        issue(1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h13, 32'd0);
        check("load_same_word", wdo_v[1], 32'hCAFEF00D);

        // Address wrap: 0x400 aliases word 0.
        issue(1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h400, 32'h11);
        issue(1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'd0);
        check("wrap_load", wdo_v[1], 32'h11);

        // Illegal load+store encoding: store happens, wdo returns old contents.
        issue(1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0, 32'h99);
        issue(1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h0, 32'd0);
        check("rbw_after", wdo_v[1], 32'h99);

        // Reset during the second stall cycle of a store drops the store.
        issue(1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h20, 32'h77);
        drive(1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h20, 32'h55);
        @(negedge clk);
        check("midrst_stall1", 32'(mstall_v[1]), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_stall_dropped", 32'(mstall_v[1]), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        nop(1);
        check("midrst_wwreg", 32'(wwreg_v[1]), 32'd0);
        check("midrst_wr", wr_v[1], 32'd0);
        check("midrst_wdo", wdo_v[1], 32'd0);
        issue(1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h20, 32'd0);
        check("midrst_mem_kept", wdo_v[1], 32'h77);
        nop(1);

        // Single-cycle instance: seed three words, then three back-to-back loads.
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 1'b0, 1'b1, 5'd0, 32'(i * 4), 32'hA000 + 32'(i));
        for (int i = 0; i < 3; i++) issue(0, 1'b1, 1'b1, 1'b0, 5'(i + 1), 32'(i * 4), 32'd0);
        check("ws0_last_load", wdo_v[0], 32'hA002);
        nop(0);

        // Randomized mix on both instances, back to back.
        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            idx  = int'($urandom_range(0, 15));
            r    = ($urandom() & 32'hFFFF_FC03) | (32'(idx) << 2);
            if (kind >= 2 && !known[s][idx]) kind = 1;
            case (kind)
                0: issue(s, 1'b1, 1'b0, 1'b0, 5'($urandom()), $urandom(), $urandom());
                1: issue(s, 1'b0, 1'b0, 1'b1, 5'($urandom()), r, $urandom());
                2: issue(s, 1'b1, 1'b1, 1'b0, 5'($urandom()), r, $urandom());
                default: issue(s, 1'($urandom()), 1'b1, 1'b1, 5'($urandom()), r, $urandom());
            endcase
            nop(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline interface in the 5-stage pipelined CPU.
- Takes the EX/MEM register outputs, performs the data-memory access for lw/sw, and inserts wait states for a configurable-latency data memory.
- Stalls upstream stages while the access is in progress, then registers the result into the MEM/WB pipeline register for the writeback stage.

Parameters:
- ADDR_W, 8: word-address width; data memory holds 2^ADDR_W 32-bit words.
- WAIT_STATES, 2: extra cycles a memory access occupies MEM. Legal range is 0..15; 0 means single-cycle.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- mwreg  in  1  instruction writes the register file.
- mm2reg  in  1  load; the writeback value comes from memory.
- mwmem  in  1  store.
- mdestReg  in  5  destination register number.
- mr  in  32  ALU result; used as the byte address for a memory op.
- mqb  in  32  store data.
- mstall  out  1  freeze request to PC/IF/ID/EX and EXEMEM; combinational.
- wwreg  out  1  MEM/WB register write enable.
- wm2reg  out  1  MEM/WB select memory data.
- wdestReg  out  5  MEM/WB destination register.
- wr  out  32  MEM/WB ALU result.
- wdo  out  32  MEM/WB memory read data.

Behaviour:
- Reset is synchronous and active-low. When resetn=0 at a rising clk edge:
  - FSM goes to IDLE and wait counter goes to 0.
  - wwreg, wm2reg, wdestReg, wr, wdo all go to 0.
  - mstall is 0 while resetn=0.
  - Memory contents are not reset.
- Memory access: a cycle with mm2reg=1 or mwmem=1. Word index is mr[ADDR_W+1:2]; mr[1:0] and upper bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- Non-access instruction:
  - Passes in 1 cycle with mstall=0.
  - At the next edge, MEM/WB captures mwreg, mm2reg, mdestReg, mr, and wdo=0.
- Access instruction:
  - Occupies MEM for WAIT_STATES+1 cycles.
  - FSM states are IDLE and BUSY, with a 4-bit counter cnt.
  - IDLE with an access and WAIT_STATES>0: mstall=1; go to BUSY with cnt=WAIT_STATES-1; MEM/WB captures a bubble (all control 0, data fields hold their previous value).
  - BUSY with cnt!=0: mstall=1; cnt decrements; bubble is captured.
  - BUSY with cnt==0: mstall=0; this is the final cycle; go to IDLE.
  - WAIT_STATES=0: the IDLE cycle is itself the final cycle.
- Final cycle of an access:
  - Store: write mqb to mem[index] exactly once.
  - Load: MEM/WB captures wdo=mem[index] (synchronous read) plus the control/data fields.
  - Total load latency from first MEM cycle to wdo valid is WAIT_STATES+1 edges.
- Upstream contract: while mstall=1, EX/MEM inputs are held stable. The block samples the inputs only on the final cycle.
- mm2reg=1 and mwmem=1 together (illegal encoding): the store is performed. wdo returns the pre-write contents (read-before-write). wm2reg=1 is propagated.
- Store with mwreg=1: propagated unchanged; the decoder guarantees 0.
- Reset mid-access (resetn=0 during BUSY):
  - FSM returns to IDLE.
  - A pending store is dropped and memory is unchanged.
  - MEM/WB outputs are zeroed.
- Back-to-back accesses: each takes the full WAIT_STATES+1 cycles. There is no overlap and no idle cycle between them.

Optional Feature:
- Macro: MEM_FWD_EN.
- When defined, adds four outputs: fwd_mvalid (1), fwd_mdest (5), fwd_mdata (32), fwd_mbusy (1).
  - fwd_mvalid = mwreg & ~mm2reg, combinational.
  - fwd_mdest = mdestReg.
  - fwd_mdata = mr.
  - fwd_mbusy = mm2reg & mwreg, so ID can detect a load-use hazard against the instruction in MEM.
  - All four are 0 while resetn=0.
- When undefined, the ports do not exist and the logic is absent.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with mwreg=1 and mr=0x1234 driven → all w* outputs are 0 and mstall=0. Release reset → the next edge gives wwreg=1 and wr=0x1234.
- ALU pass-through (WAIT_STATES=2): mwreg=1, mdestReg=5, mr=0xDEADBEEF → mstall stays 0; one edge later wwreg=1, wdestReg=5, wr=0xDEADBEEF, wdo=0.
- Store then load (WAIT_STATES=2):
  - sw with mr=0x10, mqb=0xCAFEF00D → mstall=1 for 2 cycles, then 0; wwreg stays 0.
  - lw with mr=0x13 (same word) → after 3 edges wdo=0xCAFEF00D, wm2reg=1.
- Wrap and alignment (ADDR_W=8): sw at mr=0x400 with data 0x11, then lw at mr=0x0 → wdo=0x11.
- Reset mid-store: sw with mr=0x20, mqb=0x55; assert resetn=0 on the 2nd stall cycle; release; lw at 0x20 → wdo equals the pre-test contents (not 0x55) and mstall drops in the reset cycle.
- WAIT_STATES=0: 3 back-to-back lw → mstall never asserted; one result per cycle.
